// File: rtl/seg_pkg.sv
// Shared constants, state encoding and helpers for the 7-segment scan scheduler.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } seg_state_t;

    // Digit-count field uses 0 to encode a full 8-digit display.
    function automatic logic [3:0] n_to_count(input logic [2:0] n);
        return (n == 3'd0) ? 4'd8 : {1'b0, n};
    endfunction

endpackage

// File: rtl/seg_an_decode.sv
// Active-low one-hot anode decoder; all anodes off when disabled.
module seg_an_decode
    import seg_pkg::*;
(
    input  logic [2:0] idx,
    input  logic       en,
    output logic [7:0] an
);

    always_comb begin
        an = SEG_BLANK;
        if (en) an[idx] = 1'b0;
    end

endmodule

// File: rtl/seg_scan_sched.sv
// Frame-synchronous 8-digit 7-segment scan scheduler with inter-digit blanking.
// Optional build macro SEG_BRIGHT_EN adds a 3-bit per-cycle brightness control.
//
// state    | meaning
// ST_BLANK | all segments and anodes dark before the next digit
// ST_ON    | anode idx asserted, segments from the shadow pattern
module seg_scan_sched
    import seg_pkg::*;
#(
    parameter int DWELL_CYC = 8,
    parameter int BLANK_CYC = 1
) (
    input  logic        clk_div,
    input  logic        rstn,
    input  logic [63:0] signal,
    input  logic [2:0]  n,
    input  logic        upd_req,
`ifdef SEG_BRIGHT_EN
    input  logic [2:0]  bright,
`endif
    output logic        upd_ack,
    output logic        frame_tick,
    output logic [7:0]  seg,
    output logic [7:0]  an
);

    localparam int CNT_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    seg_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic          pend, pend_nxt;
    logic [63:0]   shadow, shadow_nxt;
    logic [3:0]    n_eff, n_eff_nxt;
    logic          load;
    logic          lit;
    logic [7:0]    seg_d, an_d;
    logic          tick_d;

    always_ff @(posedge clk_div) begin
        if (!rstn) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            idx        <= '0;
            pend       <= 1'b0;
            shadow     <= '1;
            n_eff      <= 4'd8;
            seg        <= SEG_BLANK;
            an         <= SEG_BLANK;
            upd_ack    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            pend       <= pend_nxt;
            shadow     <= shadow_nxt;
            n_eff      <= n_eff_nxt;
            seg        <= seg_d;
            an         <= an_d;
            upd_ack    <= load;
            frame_tick <= tick_d;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        idx_nxt    = idx;
        shadow_nxt = shadow;
        n_eff_nxt  = n_eff;
        load       = 1'b0;
        case (state)
            ST_BLANK: begin
                if (BLANK_CYC == 0 || cnt == BLANK_LAST) begin
                    state_nxt = ST_ON;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_ON: begin
                if (cnt == DWELL_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = (BLANK_CYC == 0) ? ST_ON : ST_BLANK;
                    if ({1'b0, idx} == n_eff - 4'd1) begin
                        idx_nxt = '0;
                        load    = pend | upd_req;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = ST_BLANK;
        endcase
        if (load) begin
            shadow_nxt = signal;
            n_eff_nxt  = n_to_count(n);
        end
        pend_nxt = load ? 1'b0 : (pend | upd_req);
    end

    // Outputs are decoded from the next state so the registered outputs line up with it.
    seg_an_decode u_an_decode (
        .idx (idx_nxt),
        .en  (state_nxt == ST_ON),
        .an  (an_d)
    );

    always_comb begin
`ifdef SEG_BRIGHT_EN
        lit = (32'(cnt_nxt) < (((32'(bright) + 32'd1) * 32'(DWELL_CYC)) >> 3));
`else
        lit = 1'b1;
`endif
        seg_d  = SEG_BLANK;
        tick_d = 1'b0;
        if (state_nxt == ST_ON) begin
            if (lit) seg_d = shadow_nxt[{idx_nxt, 3'b000} +: 8];
            tick_d = (cnt_nxt == DWELL_LAST) && ({1'b0, idx_nxt} == n_eff_nxt - 4'd1);
        end
    end

endmodule

// File: tb/tb_seg_scan_sched.sv
// Scoreboard bench for seg_scan_sched: a frame-position model predicts every output cycle.
module tb_seg_scan_sched;

    logic        clk_div = 1'b0;
    logic        rstn;
    logic [63:0] signal;
    logic [2:0]  n;
    logic        upd_req;
`ifdef SEG_BRIGHT_EN
    logic [2:0]  bright;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] seg;
        logic [7:0] an;
        logic       tick;
        logic       ack;
    } obs_t;

    always #5 clk_div = ~clk_div;

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int B = (g == 0) ? 1 : 0;
        localparam int D = (g == 0) ? 8 : 3;

        logic [7:0] seg, an;
        logic       upd_ack, frame_tick;
        obs_t       exp_q[$];
        bit         started = 1'b0;

        seg_scan_sched #(.DWELL_CYC(D), .BLANK_CYC(B)) u_dut (
            .clk_div    (clk_div),
            .rstn       (rstn),
            .signal     (signal),
            .n          (n),
            .upd_req    (upd_req),
`ifdef SEG_BRIGHT_EN
            .bright     (bright),
`endif
            .upd_ack    (upd_ack),
            .frame_tick (frame_tick),
            .seg        (seg),
            .an         (an)
        );

        // Model: position within frame -> digit and phase by plain division.
        initial begin : model
            int          pos, ne, flen, dig, ph;
            logic [63:0] sh;
            bit          pend, ld, lit;
            obs_t        e;
            forever begin
                @(posedge clk_div);
                #1;
                if (!rstn) begin
                    exp_q.delete();
                    pos  = (B == 0) ? -1 : 0;
                    sh   = '1;
                    ne   = 8;
                    pend = 1'b0;
                    e    = {8'hFF, 8'hFF, 1'b0, 1'b0};
                    exp_q.push_back(e);
                    started = 1'b1;
                end else if (started) begin
                    flen = ne * (B + D);
                    ld   = 1'b0;
                    if (pos == flen - 1) ld = pend | upd_req;
                    pend = ld ? 1'b0 : (pend | upd_req);
                    if (ld) begin
                        sh = signal;
                        ne = (n == 3'd0) ? 8 : int'(n);
                    end
                    pos  = (pos == flen - 1) ? 0 : pos + 1;
                    flen = ne * (B + D);
                    dig  = pos / (B + D);
                    ph   = pos % (B + D);
`ifdef SEG_BRIGHT_EN
                    lit = (ph - B) < (((int'(bright) + 1) * D) >> 3);
`else
                    lit = 1'b1;
`endif
                    e.seg  = 8'hFF;
                    e.an   = 8'hFF;
                    e.ack  = ld;
                    e.tick = (pos == flen - 1);
                    if (ph >= B) begin
                        e.an = ~(8'h01 << dig);
                        if (lit) e.seg = sh[dig*8 +: 8];
                    end
                    exp_q.push_back(e);
                end
            end
        end

        initial begin : monitor
            obs_t e, got;
            forever begin
                @(negedge clk_div);
                if (started) begin
                    checks++;
                    got = {seg, an, frame_tick, upd_ack};
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL cfg%0d no_expectation at %0t got=%h", g, $time, got);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e)
                        begin
                            failures++;
                            $display("FAIL cfg%0d cycle_out at %0t got seg=%h an=%h tick=%b ack=%b exp seg=%h an=%h tick=%b ack=%b",
                                     g, $time, got.seg, got.an, got.tick, got.ack, e.seg, e.an, e.tick, e.ack);
                        end
                    end
                end
            end
        end
    end

    task automatic cycles(input int k);
        repeat (k) @(negedge clk_div);
    endtask

    task automatic request(input logic [63:0] sig, input logic [2:0] cnt);
        signal  = sig;
        n       = cnt;
        upd_req = 1'b1;
        @(negedge clk_div);
        upd_req = 1'b0;
    endtask

    initial begin
        rstn    = 1'b0;
        signal  = '0;
        n       = 3'd0;
        upd_req = 1'b0;
`ifdef SEG_BRIGHT_EN
        bright  = 3'd1;
`endif
        cycles(3);
        rstn = 1'b1;

        // Four digits with the known hex-digit patterns, loaded at the first frame end.
        request({$urandom(), 32'hC0F9A4B0}, 3'd4);
        cycles(72 + 36 * 3);

        // Mid-frame request: old patterns must finish the frame.
        cycles(13);
        request({$urandom(), $urandom()}, 3'd4);
        cycles(100);

        // Full 8-digit display.
        request({$urandom(), $urandom()}, 3'd0);
        cycles(220);
`ifdef SEG_BRIGHT_EN
        bright = 3'd7;
`endif
        cycles(40);

        // Reset in the middle of a frame.
        rstn = 1'b0;
        cycles(1);
        rstn = 1'b1;
        cycles(80);

        // Held request: one load per frame.
        signal  = {$urandom(), $urandom()};
        n       = 3'd3;
        upd_req = 1'b1;
        cycles(150);
        upd_req = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            upd_req = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) signal = {$urandom(), $urandom()};
            n = 3'($urandom_range(0, 7));
`ifdef SEG_BRIGHT_EN
            bright = 3'($urandom_range(0, 7));
`endif
            rstn = ($urandom_range(0, 599) != 0);
            @(negedge clk_div);
        end
        rstn    = 1'b1;
        upd_req = 1'b0;
        cycles(4);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
